// File: rtl/dom_and_gate_pkg.sv
// Shared helpers for the domain-oriented masked AND gate.
// Holds the cross-domain remask term so every lane builds it the same way.
package dom_and_gate_pkg;

    function automatic logic dom_cross_term(input logic a_s, input logic b_s, input logic z_s);
        return (a_s & b_s) ^ z_s;
    endfunction

endpackage

// File: rtl/dom_and_gate_if.sv
// Bundle of the share inputs, fresh mask and result shares of a masked AND.
// The driver side uses master, the gate side uses slave.
interface dom_and_gate_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] Ax;
    logic [WIDTH-1:0] Ay;
    logic [WIDTH-1:0] Bx;
    logic [WIDTH-1:0] By;
    logic [WIDTH-1:0] Z0;
    logic [WIDTH-1:0] Aq;
    logic [WIDTH-1:0] Bq;

    modport master (output Ax, output Ay, output Bx, output By, output Z0,
                    input Aq, input Bq);
    modport slave  (input Ax, input Ay, input Bx, input By, input Z0,
                    output Aq, output Bq);
endinterface

// File: rtl/dom_and_gate_lane.sv
// Single-bit first-order DOM-indep AND: four separate term flops, outputs XOR
// registered terms only so no unregistered path mixes the two domains.
module dom_and_lane
    import dom_and_gate_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic ax_i,
    input  logic ay_i,
    input  logic bx_i,
    input  logic by_i,
    input  logic z0_i,
    output logic aq_o,
    output logic bq_o
);

    logic raa_d;
    logic rab_d;
    logic rbb_d;
    logic rba_d;

    // Each term gets its own flop so synthesis cannot fold a cross term into
    // an inner-domain XOR ahead of the register.
    (* keep = "true" *) logic raa_q;
    (* keep = "true" *) logic rab_q;
    (* keep = "true" *) logic rbb_q;
    (* keep = "true" *) logic rba_q;

    // Next-state terms: inner products plain, cross products remasked with Z0.
    always_comb begin
        raa_d = ax_i & ay_i;
        rbb_d = bx_i & by_i;
        rab_d = dom_cross_term(ax_i, by_i, z0_i);
        rba_d = dom_cross_term(bx_i, ay_i, z0_i);
    end

    // Term registers; reset discards any in-flight product.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            raa_q <= 1'b0;
            rab_q <= 1'b0;
            rbb_q <= 1'b0;
            rba_q <= 1'b0;
        end else begin
            raa_q <= raa_d;
            rab_q <= rab_d;
            rbb_q <= rbb_d;
            rba_q <= rba_d;
        end
    end

    assign aq_o = raa_q ^ rab_q;
    assign bq_o = rbb_q ^ rba_q;

endmodule

// File: rtl/dom_and_gate.sv
// WIDTH-lane masked AND, one cycle latency, fully pipelined.
// Lanes are independent; each consumes only its own bit of Z0.
module dom_and_gate #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] Ax,
    input  logic [WIDTH-1:0] Ay,
    input  logic [WIDTH-1:0] Bx,
    input  logic [WIDTH-1:0] By,
    input  logic [WIDTH-1:0] Z0,
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] Aq,
    output logic [WIDTH-1:0] Bq
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        dom_and_lane u_lane (
            .clk  (clk),
            .rstn (rstn),
            .ax_i (Ax[g]),
            .ay_i (Ay[g]),
            .bx_i (Bx[g]),
            .by_i (By[g]),
            .z0_i (Z0[g]),
            .aq_o (Aq[g]),
            .bq_o (Bq[g])
        );
    end

endmodule

// File: tb/tb_dom_and_gate.sv
// Bench for dom_and_gate: reset, directed share vectors, per-lane exhaustive
// sweep, random streaming and a mid-stream reset against an arithmetic model.
module tb_dom_and_gate;

    localparam int W = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dom_and_gate_if #(.WIDTH(W)) bus ();

    dom_and_gate #(.WIDTH(W)) dut (
        .Ax   (bus.Ax),
        .Ay   (bus.Ay),
        .Bx   (bus.Bx),
        .By   (bus.By),
        .Z0   (bus.Z0),
        .clk  (clk),
        .rstn (rstn),
        .Aq   (bus.Aq),
        .Bq   (bus.Bq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] ax, input logic [W-1:0] ay,
                         input logic [W-1:0] bx, input logic [W-1:0] by,
                         input logic [W-1:0] z);
        bus.Ax = ax;
        bus.Ay = ay;
        bus.Bx = bx;
        bus.By = by;
        bus.Z0 = z;
    endtask

    task automatic drive_random();
        drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Model: unmask operands, AND them, and predict share A from the sampled inputs.
    task automatic tick_and_check(input string tag);
        logic [W-1:0] x, y, q, aexp;
        x    = bus.Ax ^ bus.Bx;
        y    = bus.Ay ^ bus.By;
        q    = x & y;
        aexp = (bus.Ax & bus.Ay) ^ (bus.Ax & bus.By) ^ bus.Z0;
        @(posedge clk);
        #1;
        check({tag, "_q"},  bus.Aq ^ bus.Bq, q);
        check({tag, "_aq"}, bus.Aq, aexp);
    endtask

    initial begin
        logic [4:0]   c;
        logic [W-1:0] ax, ay, bx, by, z;

        drive_random();
        #1;
        check("rst0_aq", bus.Aq, '0);
        check("rst0_bq", bus.Bq, '0);
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(posedge clk);
            #1;
            check("rst_aq", bus.Aq, '0);
            check("rst_bq", bus.Bq, '0);
        end

        @(negedge clk);
        rstn = 1'b1;

        drive('0, '1, '0, '1, '0);
        tick_and_check("zero");
        check("zero_aq", bus.Aq, '0);
        check("zero_bq", bus.Bq, '0);

        drive('1, '1, '0, '0, '1);
        tick_and_check("one");
        check("one_aq", bus.Aq, '0);
        check("one_bq", bus.Bq, '1);

        // Each lane walks all 32 share/mask combinations at a different offset.
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < W; k++) begin
                c     = 5'((i + 7 * k) % 32);
                ax[k] = c[4];
                ay[k] = c[3];
                bx[k] = c[2];
                by[k] = c[1];
                z[k]  = c[0];
            end
            drive(ax, ay, bx, by, z);
            tick_and_check("exh");
        end

        for (int i = 0; i < 200; i++) begin
            drive_random();
            tick_and_check("stream");
        end

        drive_random();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("midrst_aq", bus.Aq, '0);
        check("midrst_bq", bus.Bq, '0);
        drive_random();
        @(posedge clk);
        #1;
        check("midrst_hold_aq", bus.Aq, '0);
        check("midrst_hold_bq", bus.Bq, '0);
        @(negedge clk);
        rstn = 1'b1;
        drive_random();
        tick_and_check("post_rst");
        for (int i = 0; i < 8; i++) begin
            drive_random();
            tick_and_check("post_stream");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
